// File: rtl/sa_a_feeder_pkg.sv
// Shared constants and FSM encoding for the A-operand feeder.
// Imported by the feeder top and its skew-lane sub-module.
package sa_a_feeder_pkg;

  localparam int SARRAY_H  = 4;
  localparam int A_BUF_NUM = 2;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RET,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/sa_skew_lane.sv
// One west-edge lane: a DEPTH-stage valid+data shift chain.
// A value pushed at cycle t appears on the output at cycle t+DEPTH.
module sa_skew_lane
  import sa_a_feeder_pkg::*;
#(
  parameter int DEPTH     = 1,
  parameter int LANE_W    = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [LANE_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [LANE_W-1:0] out_data_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][LANE_W-1:0] data_q, data_d;

  always_comb begin
    valid_d[0] = in_valid_i;
    data_d[0]  = in_data_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // NOTE: these are plain flops, not a RAM, so they are all reset; that keeps
  // the array edge at valid=0/data=0 right after a mid-tile reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/sa_a_feeder.sv
// Drains one A tile per command from the double-buffered A buffer and feeds it
// to the systolic array west edge, lane j delayed by j cycles.
module sa_a_feeder
  import sa_a_feeder_pkg::*;
#(
  parameter int SARRAY_H  = sa_a_feeder_pkg::SARRAY_H,
  parameter int A_BUF_NUM = sa_a_feeder_pkg::A_BUF_NUM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill_done_valid_i,
  input  logic                         fill_done_id_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  output logic                         rd_a_buf_valid_o,
  output logic                         rd_a_buf_id_o,
  input  logic                         rd_a_buf_ret_valid_i,
  input  logic [SARRAY_H*DATA_W-1:0]   rd_a_buf_ret_data_i,
  output logic [SARRAY_H-1:0]          sa_a_valid_o,
  output logic [SARRAY_H*DATA_W-1:0]   sa_a_data_o,
  output logic                         buf_free_valid_o,
  output logic                         buf_free_id_o,
  output logic                         tile_done_o
);

  localparam int CNT_W = $clog2(SARRAY_H) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SARRAY_H - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SARRAY_H);

  state_e                 state_q, state_d;
  logic [A_BUF_NUM-1:0]   full_q, full_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]       ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_id_q, rd_id_d;
  logic                   free_valid_q, free_valid_d;
  logic                   free_id_q, free_id_d;
  logic                   tile_done_q, tile_done_d;
  logic                   capture;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    rd_ptr_d    = rd_ptr_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    flush_cnt_d = flush_cnt_q;
    cmd_ready_o = 1'b0;

    capture = rd_a_buf_ret_valid_i
              && (state_q == ST_READ || state_q == ST_WAIT_RET)
              && (ret_cnt_q < CNT_FULL);
    if (capture) ret_cnt_d = ret_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = full_q[rd_ptr_q];
        if (cmd_valid_i && cmd_ready_o) begin
          state_d     = ST_READ;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (issue_cnt_q < CNT_FULL) issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == CNT_LAST) begin
          full_d[rd_ptr_q] = 1'b0;
          rd_ptr_d         = ~rd_ptr_q;
          flush_cnt_d      = '0;
          state_d          = (ret_cnt_d == CNT_FULL) ? ST_FLUSH : ST_WAIT_RET;
        end
      end
      ST_WAIT_RET: begin
        if (ret_cnt_d == CNT_FULL) begin
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q < CNT_FULL) flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the READ-end clear so a same-cycle fill of that id wins.
    if (fill_done_valid_i) full_d[fill_done_id_i] = 1'b1;

    // Registered outputs are computed from the next state so they line up
    // with the cycle the state is actually in.
    rd_valid_d   = (state_d == ST_READ);
    rd_id_d      = rd_valid_d ? rd_ptr_q : 1'b0;
    free_valid_d = (state_d == ST_READ) && (issue_cnt_d == CNT_LAST);
    free_id_d    = free_valid_d ? rd_ptr_q : 1'b0;
    tile_done_d  = (state_d == ST_FLUSH) && (flush_cnt_d == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      full_q       <= '0;
      rd_ptr_q     <= 1'b0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_id_q      <= 1'b0;
      free_valid_q <= 1'b0;
      free_id_q    <= 1'b0;
      tile_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      rd_ptr_q     <= rd_ptr_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_id_q      <= rd_id_d;
      free_valid_q <= free_valid_d;
      free_id_q    <= free_id_d;
      tile_done_q  <= tile_done_d;
    end
  end

  assign rd_a_buf_valid_o = rd_valid_q;
  assign rd_a_buf_id_o    = rd_id_q;
  assign buf_free_valid_o = free_valid_q;
  assign buf_free_id_o    = free_id_q;
  assign tile_done_o      = tile_done_q;

  for (genvar j = 0; j < SARRAY_H; j++) begin : g_lane
    logic [DATA_W-1:0] lane_in;
    assign lane_in = capture ? rd_a_buf_ret_data_i[j*DATA_W +: DATA_W] : '0;

    sa_skew_lane #(
      .DEPTH  (j + 1),
      .LANE_W (DATA_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (capture),
      .in_data_i   (lane_in),
      .out_valid_o (sa_a_valid_o[j]),
      .out_data_o  (sa_a_data_o[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_sa_a_feeder.sv
// Directed self-checking bench for sa_a_feeder: reset, not-full, ping-pong,
// set/clear collision, stray returns and reset in WAIT_RET.
module tb_sa_a_feeder;

  localparam int H  = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              fill_done_valid_i;
  logic              fill_done_id_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              rd_a_buf_valid_o;
  logic              rd_a_buf_id_o;
  logic              rd_a_buf_ret_valid_i;
  logic [H*DW-1:0]   rd_a_buf_ret_data_i;
  logic [H-1:0]      sa_a_valid_o;
  logic [H*DW-1:0]   sa_a_data_o;
  logic              buf_free_valid_o;
  logic              buf_free_id_o;
  logic              tile_done_o;

  int n_checks = 0;
  int n_errors = 0;

  sa_a_feeder dut (
    .clk                  (clk),
    .rst                  (rst),
    .fill_done_valid_i    (fill_done_valid_i),
    .fill_done_id_i       (fill_done_id_i),
    .cmd_valid_i          (cmd_valid_i),
    .cmd_ready_o          (cmd_ready_o),
    .rd_a_buf_valid_o     (rd_a_buf_valid_o),
    .rd_a_buf_id_o        (rd_a_buf_id_o),
    .rd_a_buf_ret_valid_i (rd_a_buf_ret_valid_i),
    .rd_a_buf_ret_data_i  (rd_a_buf_ret_data_i),
    .sa_a_valid_o         (sa_a_valid_o),
    .sa_a_data_o          (sa_a_data_o),
    .buf_free_valid_o     (buf_free_valid_o),
    .buf_free_id_o        (buf_free_id_o),
    .tile_done_o          (tile_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [H*DW-1:0] obs, input logic [H*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and clear all pulse inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cmd_valid_i          = 1'b0;
    fill_done_valid_i    = 1'b0;
    fill_done_id_i       = 1'b0;
    rd_a_buf_ret_valid_i = 1'b0;
    rd_a_buf_ret_data_i  = '0;
  endtask

  task automatic drive_row(input logic [31:0] base, input int r);
    rd_a_buf_ret_valid_i = 1'b1;
    for (int j = 0; j < H; j++)
      rd_a_buf_ret_data_i[j*DW +: DW] = base + 32'(256 * r) + 32'(j);
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, ".cmd_ready"}, (H*DW)'(cmd_ready_o), (H*DW)'(exp_ready));
    check({tag, ".rd_valid"},  (H*DW)'(rd_a_buf_valid_o), '0);
    check({tag, ".buf_free"},  (H*DW)'({buf_free_valid_o, buf_free_id_o}), '0);
    check({tag, ".tile_done"}, (H*DW)'(tile_done_o), '0);
    check({tag, ".sa_valid"},  (H*DW)'(sa_a_valid_o), '0);
    check({tag, ".sa_data"},   sa_a_data_o, '0);
  endtask

  // Issues one command in the current idle cycle and checks every cycle up to
  // and including tile_done. Rows return lat cycles after each read.
  task automatic feed_tile(input string name, input logic id, input int lat,
                           input logic [31:0] base, input int fill_k,
                           input logic fill_id, input bit stray);
    logic [H-1:0]    ev;
    logic [H*DW-1:0] ed;
    int              r;
    next_cycle();
    cmd_valid_i = 1'b1;
    if (stray) begin
      rd_a_buf_ret_valid_i = 1'b1;
      rd_a_buf_ret_data_i  = {H{32'hdead_beef}};
    end
    @(negedge clk);
    check($sformatf("%s.k0.cmd_ready", name), (H*DW)'(cmd_ready_o), (H*DW)'(1));
    for (int k = 1; k <= 2 * H + lat; k++) begin
      next_cycle();
      r = k - 1 - lat;
      if (r >= 0 && r < H) drive_row(base, r);
      if (stray && k == H + lat + 1) begin
        rd_a_buf_ret_valid_i = 1'b1;
        rd_a_buf_ret_data_i  = {H{32'hbad0_0bad}};
      end
      if (k == fill_k) begin
        fill_done_valid_i = 1'b1;
        fill_done_id_i    = fill_id;
      end
      @(negedge clk);
      ev = '0;
      ed = '0;
      for (int j = 0; j < H; j++) begin
        r = k - 2 - lat - j;
        if (r >= 0 && r < H) begin
          ev[j]          = 1'b1;
          ed[j*DW +: DW] = base + 32'(256 * r) + 32'(j);
        end
      end
      check($sformatf("%s.k%0d.rd_valid", name, k), (H*DW)'(rd_a_buf_valid_o), (H*DW)'(k <= H));
      if (k <= H)
        check($sformatf("%s.k%0d.rd_id", name, k), (H*DW)'(rd_a_buf_id_o), (H*DW)'(id));
      check($sformatf("%s.k%0d.buf_free", name, k), (H*DW)'(buf_free_valid_o), (H*DW)'(k == H));
      if (k == H)
        check($sformatf("%s.k%0d.free_id", name, k), (H*DW)'(buf_free_id_o), (H*DW)'(id));
      check($sformatf("%s.k%0d.tile_done", name, k), (H*DW)'(tile_done_o), (H*DW)'(k == 2 * H + lat));
      check($sformatf("%s.k%0d.cmd_ready", name, k), (H*DW)'(cmd_ready_o), '0);
      check($sformatf("%s.k%0d.sa_valid", name, k), (H*DW)'(sa_a_valid_o), (H*DW)'(ev));
      check($sformatf("%s.k%0d.sa_data", name, k), sa_a_data_o, ed);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    cmd_valid_i          = 1'b0;
    fill_done_valid_i    = 1'b0;
    fill_done_id_i       = 1'b0;
    rd_a_buf_ret_valid_i = 1'b0;
    rd_a_buf_ret_data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("reset", 1'b0);

    // Command with nothing filled, plus a stray return while idle.
    next_cycle();
    cmd_valid_i = 1'b1;
    @(negedge clk);
    check("notfull.ready0", (H*DW)'(cmd_ready_o), '0);
    next_cycle();
    cmd_valid_i = 1'b1;
    drive_row(32'h0000_7700, 0);
    @(negedge clk);
    check_quiet("notfull.noread", 1'b0);
    next_cycle();
    fill_done_valid_i = 1'b1;
    fill_done_id_i    = 1'b0;
    @(negedge clk);
    check_quiet("fill0.same_cycle", 1'b0);

    // Tile A on buffer 0 (L=1) with stray returns; buffer 1 filled meanwhile.
    feed_tile("tileA", 1'b0, 1, 32'h0000_0000, 2, 1'b1, 1'b1);
    // Tile B back-to-back on buffer 1 (L=0); buffer 0 refilled meanwhile.
    feed_tile("tileB", 1'b1, 0, 32'h0000_1000, 2, 1'b0, 1'b0);
    // Tile C on buffer 0 with a refill of buffer 0 at its READ end.
    feed_tile("tileC", 1'b0, 1, 32'h0000_2000, H, 1'b0, 1'b0);

    // rd_ptr is now 1 and buffer 1 is empty.
    next_cycle();
    cmd_valid_i = 1'b1;
    @(negedge clk);
    check_quiet("afterC.ptr1_empty", 1'b0);
    next_cycle();
    fill_done_valid_i = 1'b1;
    fill_done_id_i    = 1'b1;
    @(negedge clk);
    check("fill1.ready0", (H*DW)'(cmd_ready_o), '0);
    feed_tile("tileD", 1'b1, 0, 32'h0000_3000, -1, 1'b0, 1'b0);

    // Tile E: rd_ptr back to 0 and full[0] kept by the collision; reset mid-tile.
    next_cycle();
    cmd_valid_i = 1'b1;
    @(negedge clk);
    check("tileE.ready_collision", (H*DW)'(cmd_ready_o), (H*DW)'(1));
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 2 || k == 3) drive_row(32'h0000_4000, k - 2);
      if (k == 4) begin
        fill_done_valid_i = 1'b1;
        fill_done_id_i    = 1'b0;
      end
      if (k == 5) rst = 1'b1;
      @(negedge clk);
      if (k == 4) check("tileE.free", (H*DW)'({buf_free_valid_o, buf_free_id_o}), (H*DW)'(2'b10));
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset", 1'b0);
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      if (k < 4) drive_row(32'h0000_5000, k);
      @(negedge clk);
      check($sformatf("post_reset.k%0d.free_done", k),
            (H*DW)'({buf_free_valid_o, tile_done_o}), '0);
      check($sformatf("post_reset.k%0d.sa_valid", k), (H*DW)'(sa_a_valid_o), '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
